// File: rtl/score_recorder.sv
// score_recorder
//
// Captures live key input and writes it into score RAM as (note, tone)
// entries, using the same encoding the score player reads back: an entry
// plays for (note+1) units of DELAY clocks. Leading silence before the first
// key is skipped. A segment shorter than one unit is dropped as a key glitch.
// A segment that reaches 128 units is split into a 127 entry plus a
// continuation.
//
// Optional feature (macro SCORE_END_MARK_EN): after the stop flush, one extra
// terminator entry (tone 0, note 127) is written, unless the take is full.
//
// Parameters:
//   DELAY     clocks per 1/128-note unit (>= 2, must match the player)
//   ADDR_MAX  highest RAM address written
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   key_tone_i    currently pressed tone code, 0 = rest/no key
//   rec_start_i   one-cycle pulse, begin recording
//   rec_stop_i    one-cycle pulse, end recording
//   wr_en_o       RAM write strobe, one cycle per entry
//   wr_addr_o     RAM write address
//   wr_note_o     duration field written (units-1)
//   wr_tone_o     tone field written
//   recording_o   high while armed or recording
//   full_o        last written address was ADDR_MAX
//   length_o      number of entries written this take

module score_recorder #(
    parameter int DELAY    = 735000,
    parameter int ADDR_MAX = 610
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] key_tone_i,
    input  logic       rec_start_i,
    input  logic       rec_stop_i,
    output logic       wr_en_o,
    output logic [9:0] wr_addr_o,
    output logic [6:0] wr_note_o,
    output logic [6:0] wr_tone_o,
    output logic       recording_o,
    output logic       full_o,
    output logic [9:0] length_o
);

    localparam int TICK_W = $clog2(DELAY);

`ifdef SCORE_END_MARK_EN
    typedef enum logic [2:0] {IDLE, ARM, REC, MARK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARM, REC, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        dur_q, dur_d;
    logic [6:0]        seg_tone_q, seg_tone_d;
    logic [9:0]        addr_q, addr_d;
    logic [9:0]        length_q, length_d;
    logic              full_q, full_d;
    logic              recording_q, recording_d;
    logic              wr_en_q, wr_en_d;
    logic [9:0]        wr_addr_q, wr_addr_d;
    logic [6:0]        wr_note_q, wr_note_d;
    logic [6:0]        wr_tone_q, wr_tone_d;

    logic              do_write;
    logic [6:0]        commit_note;
    logic [6:0]        commit_tone;

    // Next-state logic. Each branch decides whether an entry is committed.
    // The shared write bookkeeping below the case then issues it, and may
    // force DONE when the last address is consumed.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        dur_d       = dur_q;
        seg_tone_d  = seg_tone_q;
        addr_d      = addr_q;
        length_d    = length_q;
        full_d      = full_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_note_d   = wr_note_q;
        wr_tone_d   = wr_tone_q;
        do_write    = 1'b0;
        commit_note = 7'd0;
        commit_tone = 7'd0;

        case (state_q)
            IDLE, DONE: begin
                // A simultaneous stop cancels the start.
                if (rec_start_i && !rec_stop_i) begin
                    state_d  = ARM;
                    addr_d   = 10'd0;
                    length_d = 10'd0;
                    full_d   = 1'b0;
                end
            end

            ARM: begin
                if (rec_stop_i) begin
                    state_d = DONE;
                end else if (key_tone_i != 7'd0) begin
                    seg_tone_d = key_tone_i;
                    dur_d      = 8'd0;
                    tick_d     = '0;
                    state_d    = REC;
                end
            end

            REC: begin
                if (rec_stop_i) begin
                    // Only the outgoing segment is flushed, even when the
                    // key also changes on this edge.
                    if (dur_q != 8'd0) begin
                        do_write    = 1'b1;
                        commit_note = 7'(dur_q - 8'd1);
                        commit_tone = seg_tone_q;
                    end
`ifdef SCORE_END_MARK_EN
                    state_d = MARK;
`else
                    state_d = DONE;
`endif
                end else if (key_tone_i != seg_tone_q) begin
                    // Segments shorter than one unit are dropped silently.
                    if (dur_q != 8'd0) begin
                        do_write    = 1'b1;
                        commit_note = 7'(dur_q - 8'd1);
                        commit_tone = seg_tone_q;
                    end
                    seg_tone_d = key_tone_i;
                    dur_d      = 8'd0;
                    tick_d     = '0;
                end else if (tick_q == TICK_W'(DELAY - 1)) begin
                    tick_d = '0;
                    if (dur_q == 8'd127) begin
                        // The note field cannot hold 128 units: emit a full
                        // entry and continue the same tone as a new segment.
                        do_write    = 1'b1;
                        commit_note = 7'd127;
                        commit_tone = seg_tone_q;
                        dur_d       = 8'd0;
                    end else begin
                        dur_d = dur_q + 8'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

`ifdef SCORE_END_MARK_EN
            MARK: begin
                do_write    = 1'b1;
                commit_note = 7'd127;
                commit_tone = 7'd0;
                state_d     = DONE;
            end
`endif

            default: state_d = IDLE;
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_note_d = commit_note;
            wr_tone_d = commit_tone;
            length_d  = length_q + 10'd1;
            if (addr_q == 10'(ADDR_MAX)) begin
                // The address does not wrap; later activity is ignored.
                full_d  = 1'b1;
                state_d = DONE;
            end else begin
                addr_d = addr_q + 10'd1;
            end
        end

        recording_d = (state_d == ARM) || (state_d == REC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            dur_q       <= 8'd0;
            seg_tone_q  <= 7'd0;
            addr_q      <= 10'd0;
            length_q    <= 10'd0;
            full_q      <= 1'b0;
            recording_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 10'd0;
            wr_note_q   <= 7'd0;
            wr_tone_q   <= 7'd0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            dur_q       <= dur_d;
            seg_tone_q  <= seg_tone_d;
            addr_q      <= addr_d;
            length_q    <= length_d;
            full_q      <= full_d;
            recording_q <= recording_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_note_q   <= wr_note_d;
            wr_tone_q   <= wr_tone_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_note_o   = wr_note_q;
    assign wr_tone_o   = wr_tone_q;
    assign recording_o = recording_q;
    assign full_o      = full_q;
    assign length_o    = length_q;

endmodule
